mem_stall_ctrl: RTL

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/stall_perf_cnt.sv | 31 +++
 rtl/mem_stall_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared pipeline-control types: controller state encoding, stall/flush vectors and their decode.
// Pure combinational helpers; no state, no flow control.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        ADVANCE = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stall_t;

    typedef struct packed {
        logic ifid;
        logic idex;
    } flush_t;

    localparam stall_t STALL_ALL  = stall_t'(5'b11111);
    localparam stall_t STALL_NONE = stall_t'(5'b00000);
    localparam flush_t FLUSH_NONE = flush_t'(2'b00);

    // The pipeline only moves in ADVANCE; a taken branch outranks a load-use bubble.
    function automatic stall_t stall_decode(input ctrl_state_t s,
                                            input logic        load_use,
                                            input logic        branch_taken);
        stall_t st;
        st = STALL_ALL;
        if (s == ADVANCE) begin
            if (branch_taken) begin
                st = STALL_NONE;
            end else if (load_use) begin
                st = stall_t'(5'b11000);
            end else begin
                st = STALL_NONE;
            end
        end
        return st;
    endfunction

    function automatic flush_t flush_decode(input ctrl_state_t s,
                                            input logic        load_use,
                                            input logic        branch_taken);
        flush_t fl;
        fl = FLUSH_NONE;
        if (s == ADVANCE) begin
            if (branch_taken) begin
                fl = flush_t'(2'b11);
            end else if (load_use) begin
                fl = flush_t'(2'b01);
            end
        end
        return fl;
    endfunction

endpackage

// File: rtl/stall_perf_cnt.sv
// Saturating stall-cycle and retired-slot counters for the memory stall controller.
// Counts on the edge after the qualifying cycle; never wraps, no backpressure.
module stall_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_stall,
    input  logic             inc_instr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            instr_count  <= '0;
        end else begin
            if (inc_stall && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (inc_instr && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Holds the pipeline while instruction/data AXI transactions are outstanding; optional counters under STALL_PERF_CNT_EN.
// Minimum slot ISSUE->WAIT->ADVANCE = 3 cycles; the pipeline stays stalled until every started transaction reports done.
module mem_stall_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dm_rd,
    input  logic             dm_wr,
    input  logic             im_done,
    input  logic             dm_done,
    input  logic             load_use,
    input  logic             branch_taken,
    output logic             im_start,
    output logic             dm_start,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             stall_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] instr_count
);

    ctrl_state_t state;
    logic        im_pending;
    logic        dm_pending;
    logic        im_left;
    logic        dm_left;
    logic        issue_st;
    stall_t      stall;
    flush_t      flush;

    // Done pulses only matter for a flag that is still set; stray pulses fall out here.
    assign im_left  = im_pending & ~im_done;
    assign dm_left  = dm_pending & ~dm_done;
    assign issue_st = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            im_pending <= 1'b0;
            dm_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    im_pending <= 1'b1;
                    dm_pending <= dm_rd | dm_wr;
                    state      <= WAIT;
                end
                WAIT: begin
                    im_pending <= im_left;
                    dm_pending <= dm_left;
                    if (!im_left && !dm_left) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    state <= ISSUE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset forces the safe output pattern even before the first clock edge lands.
    assign im_start = rst & issue_st;
    assign dm_start = rst & issue_st & (dm_rd | dm_wr);
    assign stall    = rst ? stall_decode(state, load_use, branch_taken) : STALL_ALL;
    assign flush    = rst ? flush_decode(state, load_use, branch_taken) : FLUSH_NONE;

    assign stall_pc    = stall.pc;
    assign stall_ifid  = stall.ifid;
    assign stall_idex  = stall.idex;
    assign stall_exmem = stall.exmem;
    assign stall_memwb = stall.memwb;
    assign flush_ifid  = flush.ifid;
    assign flush_idex  = flush.idex;

`ifdef STALL_PERF_CNT_EN
    logic inc_stall;
    logic inc_instr;

    assign inc_stall = (state == WAIT);
    assign inc_instr = (state == ADVANCE) & ~load_use & ~branch_taken;

    stall_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .inc_stall    (inc_stall),
        .inc_instr    (inc_instr),
        .stall_cycles (stall_cycles),
        .instr_count  (instr_count)
    );
`else
    assign stall_cycles = '0;
    assign instr_count  = '0;
`endif

endmodule
